multichannel_section_window_meter: RTL and testbench



---
 rtl/multichannel_section_window_meter.sv | 252 +++++++++++++++++++++++++
 tb/tb_multichannel_section_window_meter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_section_window_meter.sv
// multichannel_section_window_meter
// Accepts time-interleaved samples tagged with a channel index, tracks the
// min/max of each channel over sections of sample_count samples, keeps the
// last buffer_depth section results per channel in a ring, and after every
// completed section reports that channel's window min, max and peak-to-peak.
//
// Ports:
//   clk          clock, everything on the rising edge
//   reset        synchronous active-low reset
//   i_valid      sample valid
//   i_ready      block can accept a sample (high only while idle)
//   i_channel    channel tag of the sample
//   i_value      sample value
//   o_valid      window result valid
//   o_ready      downstream accepts the result
//   o_channel    channel the result belongs to
//   o_value      window max minus window min
//   o_min_value  window minimum
//   o_max_value  window maximum
module multichannel_section_window_meter #(
   parameter int width        = 16,
   parameter int sample_count = 4,
   parameter int buffer_depth = 4,
   parameter int channels     = 2,
   parameter int is_signed    = 0,
   localparam int cw          = (channels > 1) ? $clog2(channels) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [cw-1:0]    i_channel,
   input  logic [width-1:0] i_value,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [cw-1:0]    o_channel,
   output logic [width-1:0] o_value,
   output logic [width-1:0] o_min_value,
   output logic [width-1:0] o_max_value
);

   localparam int scw = (sample_count > 1) ? $clog2(sample_count) : 1;
   localparam int pw  = (buffer_depth > 1) ? $clog2(buffer_depth) : 1;
   localparam int fw  = $clog2(buffer_depth + 1);

   localparam logic [scw-1:0] cnt_last = scw'(sample_count - 1);
   localparam logic [scw-1:0] cnt_one  = scw'(1);
   localparam logic [pw-1:0]  ptr_last = pw'(buffer_depth - 1);
   localparam logic [pw-1:0]  ptr_one  = pw'(1);
   localparam logic [fw-1:0]  fill_max = fw'(buffer_depth);
   localparam logic [fw-1:0]  fill_one = fw'(1);
   localparam logic [cw:0]    ch_limit = (cw + 1)'(channels);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // a < b in the selected comparison mode
   function automatic logic less_than(input logic [width-1:0] a, input logic [width-1:0] b);
      if (is_signed != 0) begin
         less_than = ($signed(a) < $signed(b));
      end else begin
         less_than = (a < b);
      end
   endfunction

   state_t           state_r;
   logic             i_ready_r;
   logic             o_valid_r;
   logic [cw-1:0]    o_channel_r;
   logic [width-1:0] o_value_r;
   logic [width-1:0] o_min_r;
   logic [width-1:0] o_max_r;

   logic [scw-1:0]   cnt_r     [channels];
   logic [width-1:0] acc_min_r [channels];
   logic [width-1:0] acc_max_r [channels];
   logic [pw-1:0]    wr_ptr_r  [channels];
   logic [fw-1:0]    fill_r    [channels];
   logic [width-1:0] ring_min_r [channels][buffer_depth];
   logic [width-1:0] ring_max_r [channels][buffer_depth];

   // Window scan: one ring entry is read per cycle into rd_*, and folded
   // into win_* the following cycle.
   logic [cw-1:0]    scan_ch_r;
   logic [fw-1:0]    scan_idx_r;
   logic             rd_pend_r;
   logic [width-1:0] rd_min_r;
   logic [width-1:0] rd_max_r;
   logic [width-1:0] win_min_r;
   logic [width-1:0] win_max_r;
   logic             win_first_r;

   logic             in_xfer_s;
   logic             ch_ok_s;
   logic             complete_s;
   logic [width-1:0] samp_min_s;
   logic [width-1:0] samp_max_s;
   logic [width-1:0] fold_min_s;
   logic [width-1:0] fold_max_s;
   logic [fw-1:0]    scan_fill_s;

   assign in_xfer_s   = i_valid && i_ready_r;
   assign ch_ok_s     = ({1'b0, i_channel} < ch_limit);
   assign complete_s  = in_xfer_s && ch_ok_s && (cnt_r[i_channel] == cnt_last);
   assign scan_fill_s = fill_r[scan_ch_r];

   // Section min/max including the sample being accepted now
   always_comb begin
      samp_min_s = i_value;
      samp_max_s = i_value;
      if (cnt_r[i_channel] != {scw{1'b0}}) begin
         samp_min_s = less_than(acc_min_r[i_channel], i_value) ? acc_min_r[i_channel] : i_value;
         samp_max_s = less_than(i_value, acc_max_r[i_channel]) ? acc_max_r[i_channel] : i_value;
      end else begin
         samp_min_s = i_value;
         samp_max_s = i_value;
      end
   end

   // Window min/max after folding the ring entry held in rd_*
   always_comb begin
      fold_min_s = rd_min_r;
      fold_max_s = rd_max_r;
      if (win_first_r) begin
         fold_min_s = rd_min_r;
         fold_max_s = rd_max_r;
      end else begin
         fold_min_s = less_than(rd_min_r, win_min_r) ? rd_min_r : win_min_r;
         fold_max_s = less_than(win_max_r, rd_max_r) ? rd_max_r : win_max_r;
      end
   end

   // Per-channel section counter, accumulator, ring pointer and fill count
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int c = 0; c < channels; c++) begin
            cnt_r[c]     <= {scw{1'b0}};
            acc_min_r[c] <= {width{1'b0}};
            acc_max_r[c] <= {width{1'b0}};
            wr_ptr_r[c]  <= {pw{1'b0}};
            fill_r[c]    <= {fw{1'b0}};
         end
      end else if (in_xfer_s && ch_ok_s) begin
         if (complete_s) begin
            cnt_r[i_channel]     <= {scw{1'b0}};
            acc_min_r[i_channel] <= {width{1'b0}};
            acc_max_r[i_channel] <= {width{1'b0}};
            wr_ptr_r[i_channel]  <= (wr_ptr_r[i_channel] == ptr_last) ? {pw{1'b0}}
                                                                     : wr_ptr_r[i_channel] + ptr_one;
            if (fill_r[i_channel] != fill_max) begin
               fill_r[i_channel] <= fill_r[i_channel] + fill_one;
            end
         end else begin
            cnt_r[i_channel]     <= cnt_r[i_channel] + cnt_one;
            acc_min_r[i_channel] <= samp_min_s;
            acc_max_r[i_channel] <= samp_max_s;
         end
      end
   end

   // Ring storage: contents need no reset because fill gates every read
   always_ff @(posedge clk) begin
      if (complete_s) begin
         ring_min_r[i_channel][wr_ptr_r[i_channel]] <= samp_min_s;
         ring_max_r[i_channel][wr_ptr_r[i_channel]] <= samp_max_s;
      end
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         i_ready_r   <= 1'b0;
         o_valid_r   <= 1'b0;
         o_channel_r <= {cw{1'b0}};
         o_value_r   <= {width{1'b0}};
         o_min_r     <= {width{1'b0}};
         o_max_r     <= {width{1'b0}};
         scan_ch_r   <= {cw{1'b0}};
         scan_idx_r  <= {fw{1'b0}};
         rd_pend_r   <= 1'b0;
         rd_min_r    <= {width{1'b0}};
         rd_max_r    <= {width{1'b0}};
         win_min_r   <= {width{1'b0}};
         win_max_r   <= {width{1'b0}};
         win_first_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               o_valid_r <= 1'b0;
               if (complete_s) begin
                  state_r     <= ST_SCAN;
                  i_ready_r   <= 1'b0;
                  scan_ch_r   <= i_channel;
                  scan_idx_r  <= {fw{1'b0}};
                  rd_pend_r   <= 1'b0;
                  win_first_r <= 1'b1;
               end else begin
                  i_ready_r <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (rd_pend_r) begin
                  win_min_r   <= fold_min_s;
                  win_max_r   <= fold_max_s;
                  win_first_r <= 1'b0;
               end
               if (scan_idx_r < scan_fill_s) begin
                  rd_min_r   <= ring_min_r[scan_ch_r][scan_idx_r[pw-1:0]];
                  rd_max_r   <= ring_max_r[scan_ch_r][scan_idx_r[pw-1:0]];
                  rd_pend_r  <= 1'b1;
                  scan_idx_r <= scan_idx_r + fill_one;
               end else begin
                  // All valid entries read; the one in rd_* is the last fold
                  rd_pend_r <= 1'b0;
                  if (rd_pend_r) begin
                     state_r     <= ST_OUT;
                     o_valid_r   <= 1'b1;
                     o_channel_r <= scan_ch_r;
                     o_min_r     <= fold_min_s;
                     o_max_r     <= fold_max_s;
                     o_value_r   <= fold_max_s - fold_min_s;
                  end
               end
            end
            ST_OUT: begin
               if (o_ready) begin
                  state_r   <= ST_IDLE;
                  o_valid_r <= 1'b0;
                  i_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               i_ready_r <= 1'b0;
               o_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign i_ready     = i_ready_r;
   assign o_valid     = o_valid_r;
   assign o_channel   = o_channel_r;
   assign o_value     = o_value_r;
   assign o_min_value = o_min_r;
   assign o_max_value = o_max_r;

endmodule

// File: tb/tb_multichannel_section_window_meter.sv
// Testbench for multichannel_section_window_meter. Two instances share all
// inputs: dut compares unsigned, dut_s compares signed. Expected windows come
// from a sample-history model: the window of a channel is simply the min/max
// over its last buffer_depth*sample_count accepted samples.
module tb_multichannel_section_window_meter;

   localparam int W  = 16;
   localparam int SC = 4;
   localparam int D  = 4;
   localparam int CH = 2;
   localparam int CW = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready = 1'b0;
   logic [CW-1:0] i_channel = '0;
   logic [W-1:0]  i_value = '0;

   logic          i_ready, o_valid;
   logic [CW-1:0] o_channel;
   logic [W-1:0]  o_value, o_min_value, o_max_value;
   logic          s_i_ready, s_o_valid;
   logic [CW-1:0] s_o_channel;
   logic [W-1:0]  s_o_value, s_o_min_value, s_o_max_value;

   int errors = 0;
   int checks = 0;

   int           hq_ch[$];
   logic [15:0]  hq_v[$];
   int           pend[CH];

   multichannel_section_window_meter #(.width(W), .sample_count(SC), .buffer_depth(D),
                                       .channels(CH), .is_signed(0)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
      .i_channel(i_channel), .i_value(i_value), .o_valid(o_valid), .o_ready(o_ready),
      .o_channel(o_channel), .o_value(o_value), .o_min_value(o_min_value),
      .o_max_value(o_max_value));

   multichannel_section_window_meter #(.width(W), .sample_count(SC), .buffer_depth(D),
                                       .channels(CH), .is_signed(1)) dut_s (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(s_i_ready),
      .i_channel(i_channel), .i_value(i_value), .o_valid(s_o_valid), .o_ready(o_ready),
      .o_channel(s_o_channel), .o_value(s_o_value), .o_min_value(s_o_min_value),
      .o_max_value(s_o_max_value));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int key(input logic [15:0] v, input bit sgn);
      if (sgn && v[15]) return int'(v) - 65536;
      else return int'(v);
   endfunction

   task automatic model_window(input int ch, input bit sgn, output logic [15:0] mn, output logic [15:0] mx);
      int n = 0;
      bit first = 1'b1;
      mn = 16'h0000;
      mx = 16'h0000;
      for (int i = hq_v.size() - 1; i >= 0 && n < D * SC; i--) begin
         if (hq_ch[i] == ch) begin
            if (first || key(hq_v[i], sgn) < key(mn, sgn)) mn = hq_v[i];
            if (first || key(hq_v[i], sgn) > key(mx, sgn)) mx = hq_v[i];
            first = 1'b0;
            n++;
         end
      end
   endtask

   task automatic model_clear();
      hq_ch.delete();
      hq_v.delete();
      for (int c = 0; c < CH; c++) pend[c] = 0;
   endtask

   task automatic model_push(input int ch, input logic [15:0] v, output bit done);
      hq_ch.push_back(ch);
      hq_v.push_back(v);
      pend[ch]++;
      done = (pend[ch] == SC);
      if (done) pend[ch] = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      i_valid = 1'b0;
      o_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input logic [15:0] v, output bit done,
                       output logic [15:0] umin, output logic [15:0] umax,
                       output logic [15:0] smin, output logic [15:0] smax);
      int n = 0;
      while (i_ready !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (i_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready_timeout: i_ready=%b required 1", i_ready);
      end
      i_valid = 1'b1;
      i_channel = ch[CW-1:0];
      i_value = v;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      model_push(ch, v, done);
      model_window(ch, 1'b0, umin, umax);
      model_window(ch, 1'b1, smin, smax);
   endtask

   task automatic wait_result(output bit got, output int edges);
      edges = 0;
      while (o_valid !== 1'b1 && edges < 64) begin
         @(posedge clk);
         #1;
         edges++;
      end
      got = (o_valid === 1'b1);
   endtask

   task automatic ack();
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      o_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      i_valid = 1'b0;
      o_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({i_ready, o_valid, s_i_ready, s_o_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_handshake: ready/valid=%b required 0000", {i_ready, o_valid, s_i_ready, s_o_valid});
      end
      checks++;
      if (o_channel !== 1'b0) begin
         errors++;
         $display("FAIL reset_o_channel: got %h required 0", o_channel);
      end
      checks++;
      if (o_value !== 16'h0000) begin
         errors++;
         $display("FAIL reset_o_value: got %h required 0000", o_value);
      end
      checks++;
      if ({o_min_value, o_max_value} !== 32'h0) begin
         errors++;
         $display("FAIL reset_min_max: got %h/%h required 0000/0000", o_min_value, o_max_value);
      end
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      checks++;
      if (i_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b required 1", i_ready);
      end
   endtask

   task automatic test_basic_window();
      logic [15:0] secs [14];
      logic [15:0] exp_val [14];
      logic [15:0] umin, umax, smin, smax;
      bit done, got;
      int edges;
      secs = '{16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
               16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hFFFF, 16'h1111};
      exp_val = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'h2222, 16'h3333,
                  16'h3333, 16'h3333, 16'h3333, 16'h3333, 16'h3333, 16'h8888, 16'hEEEE};
      do_reset();
      for (int s = 0; s < 14; s++) begin
         for (int k = 0; k < SC; k++) send(0, secs[s], done, umin, umax, smin, smax);
         wait_result(got, edges);
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL basic_no_result: section %0d o_valid=%b required 1", s, o_valid);
         end
         checks++;
         if ({o_channel, o_value, o_min_value, o_max_value} !== {1'b0, exp_val[s], umin, umax}) begin
            errors++;
            $display("FAIL basic_window: section %0d got ch=%h val=%h min=%h max=%h required ch=0 val=%h min=%h max=%h",
                     s, o_channel, o_value, o_min_value, o_max_value, exp_val[s], umin, umax);
         end
         if (s == 13) begin
            checks++;
            if ({o_min_value, o_max_value} !== {16'h1111, 16'hFFFF}) begin
               errors++;
               $display("FAIL basic_final_window: got min=%h max=%h required 1111/FFFF", o_min_value, o_max_value);
            end
         end
         ack();
      end
   endtask

   task automatic test_partial_latency();
      logic [15:0] vals [4];
      logic [15:0] umin, umax, smin, smax;
      bit done, got;
      int edges;
      vals = '{16'h1230, 16'h1234, 16'h1232, 16'h1231};
      do_reset();
      for (int k = 0; k < 4; k++) send(1, vals[k], done, umin, umax, smin, smax);
      wait_result(got, edges);
      checks++;
      if (!got || edges != 2) begin
         errors++;
         $display("FAIL latency: o_valid after %0d edges (valid=%b) required 2", edges, o_valid);
      end
      checks++;
      if ({o_channel, o_value, o_min_value, o_max_value} !== {1'b1, 16'h0004, 16'h1230, 16'h1234}) begin
         errors++;
         $display("FAIL partial_fill: got ch=%h val=%h min=%h max=%h required ch=1 val=0004 min=1230 max=1234",
                  o_channel, o_value, o_min_value, o_max_value);
      end
      ack();
   endtask

   task automatic test_interleave();
      logic [15:0] umin, umax, smin, smax;
      logic [15:0] v;
      bit done, got;
      int edges;
      int ch;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         ch = i % 2;
         v = (ch == 1) ? 16'h0F00 : 16'h0100;
         send(ch, v, done, umin, umax, smin, smax);
         if (done) begin
            wait_result(got, edges);
            checks++;
            if (!got || {o_channel, o_value, o_min_value, o_max_value} !== {ch[0], 16'h0000, v, v}) begin
               errors++;
               $display("FAIL interleave: accept %0d got valid=%b ch=%h val=%h min=%h max=%h required ch=%0d val=0000 min=%h max=%h",
                        i, o_valid, o_channel, o_value, o_min_value, o_max_value, ch, v, v);
            end
            ack();
         end
      end
   endtask

   task automatic test_signed();
      logic [15:0] vals [4];
      logic [15:0] umin, umax, smin, smax;
      bit done, got;
      int edges;
      vals = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0001};
      do_reset();
      for (int k = 0; k < 4; k++) send(0, vals[k], done, umin, umax, smin, smax);
      wait_result(got, edges);
      checks++;
      if (!got || {o_value, o_min_value, o_max_value} !== {16'h8000, 16'h0000, 16'h8000}) begin
         errors++;
         $display("FAIL unsigned_mode: got valid=%b val=%h min=%h max=%h required val=8000 min=0000 max=8000",
                  o_valid, o_value, o_min_value, o_max_value);
      end
      checks++;
      if (s_o_valid !== 1'b1 || {s_o_value, s_o_min_value, s_o_max_value} !== {16'hFFFF, 16'h8000, 16'h7FFF}) begin
         errors++;
         $display("FAIL signed_mode: got valid=%b val=%h min=%h max=%h required val=FFFF min=8000 max=7FFF",
                  s_o_valid, s_o_value, s_o_min_value, s_o_max_value);
      end
      ack();
   endtask

   task automatic test_backpressure();
      logic [15:0] vals [4];
      logic [15:0] tail [3];
      logic [15:0] umin, umax, smin, smax;
      logic [49:0] snap;
      bit done, got;
      int edges;
      vals = '{16'h0005, 16'h0009, 16'h0003, 16'h0007};
      tail = '{16'h0040, 16'h0041, 16'h0043};
      do_reset();
      for (int k = 0; k < 4; k++) send(0, vals[k], done, umin, umax, smin, smax);
      wait_result(got, edges);
      checks++;
      if (!got || {o_value, o_min_value, o_max_value} !== {16'h0006, 16'h0003, 16'h0009}) begin
         errors++;
         $display("FAIL bp_result: got valid=%b val=%h min=%h max=%h required val=0006 min=0003 max=0009",
                  o_valid, o_value, o_min_value, o_max_value);
      end
      snap = {1'b1, 1'b0, 16'h0006, 16'h0003, 16'h0009};
      i_valid = 1'b1;
      i_channel = 1'b1;
      i_value = 16'h0042;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({o_valid, i_ready, o_value, o_min_value, o_max_value} !== snap) begin
            errors++;
            $display("FAIL bp_stall: cycle %0d got valid=%b ready=%b val=%h min=%h max=%h required valid=1 ready=0 val=0006 min=0003 max=0009",
                     c, o_valid, i_ready, o_value, o_min_value, o_max_value);
         end
      end
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      o_ready = 1'b0;
      checks++;
      if ({o_valid, i_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: got valid=%b ready=%b required valid=0 ready=1", o_valid, i_ready);
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      model_push(1, 16'h0042, done);
      for (int k = 0; k < 3; k++) send(1, tail[k], done, umin, umax, smin, smax);
      wait_result(got, edges);
      checks++;
      if (!got || {o_channel, o_value, o_min_value, o_max_value} !== {1'b1, 16'h0003, 16'h0040, 16'h0043}) begin
         errors++;
         $display("FAIL bp_held_sample: got valid=%b ch=%h val=%h min=%h max=%h required ch=1 val=0003 min=0040 max=0043",
                  o_valid, o_channel, o_value, o_min_value, o_max_value);
      end
      ack();
   endtask

   task automatic test_reset_mid_scan();
      logic [15:0] umin, umax, smin, smax;
      bit done, got;
      int edges;
      do_reset();
      for (int k = 0; k < 4; k++) send(0, 16'h3333, done, umin, umax, smin, smax);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({o_valid, i_ready, o_value, o_min_value, o_max_value} !== 50'h0) begin
         errors++;
         $display("FAIL midscan_reset_outputs: got valid=%b ready=%b val=%h min=%h max=%h required all 0",
                  o_valid, i_ready, o_value, o_min_value, o_max_value);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midscan_spurious_valid: cycle %0d o_valid=%b required 0", c, o_valid);
         end
      end
      for (int k = 0; k < 4; k++) send(0, 16'h2222, done, umin, umax, smin, smax);
      wait_result(got, edges);
      checks++;
      if (!got || edges != 2 || {o_value, o_min_value, o_max_value} !== {16'h0000, 16'h2222, 16'h2222}) begin
         errors++;
         $display("FAIL midscan_next_section: edges=%0d valid=%b val=%h min=%h max=%h required edges=2 val=0000 min=2222 max=2222",
                  edges, o_valid, o_value, o_min_value, o_max_value);
      end
      ack();
   endtask

   task automatic test_random();
      logic [15:0] corner [4];
      logic [15:0] umin, umax, smin, smax;
      logic [15:0] v;
      bit done, got;
      int edges;
      int ch;
      corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
      do_reset();
      for (int i = 0; i < 96; i++) begin
         ch = int'($urandom_range(0, CH - 1));
         if ($urandom_range(0, 3) == 0) v = corner[$urandom_range(0, 3)];
         else v = 16'($urandom);
         send(ch, v, done, umin, umax, smin, smax);
         if (done) begin
            wait_result(got, edges);
            checks++;
            if (!got || {o_channel, o_value, o_min_value, o_max_value} !== {ch[0], 16'(umax - umin), umin, umax}) begin
               errors++;
               $display("FAIL random_unsigned: accept %0d got valid=%b ch=%h val=%h min=%h max=%h required ch=%0d val=%h min=%h max=%h",
                        i, o_valid, o_channel, o_value, o_min_value, o_max_value, ch, 16'(umax - umin), umin, umax);
            end
            checks++;
            if (s_o_valid !== 1'b1 || {s_o_channel, s_o_value, s_o_min_value, s_o_max_value} !== {ch[0], 16'(smax - smin), smin, smax}) begin
               errors++;
               $display("FAIL random_signed: accept %0d got valid=%b ch=%h val=%h min=%h max=%h required ch=%0d val=%h min=%h max=%h",
                        i, s_o_valid, s_o_channel, s_o_value, s_o_min_value, s_o_max_value, ch, 16'(smax - smin), smin, smax);
            end
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            ack();
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_window();
      test_partial_latency();
      test_interleave();
      test_signed();
      test_backpressure();
      test_reset_mid_scan();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
